// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet path.
// Optional statistics counters are enabled with the PS2_PKT_STATS_EN macro.
package ps2_pkg;

    typedef enum logic [1:0] {PKT_B0, PKT_B1, PKT_B2} ps2_pkt_state_t;

    localparam int SYNC_BIT = 3;

    // Status-byte field positions, for consumers that decode byte0.
    localparam int L_BTN = 0;
    localparam int R_BTN = 1;
    localparam int X_NEG = 4;
    localparam int Y_NEG = 5;
    localparam int X_OVF = 6;
    localparam int Y_OVF = 7;

    function automatic logic is_status_byte(input logic [7:0] b);
        return b[SYNC_BIT];
    endfunction

endpackage

// File: rtl/ps2_byte_timeout.sv
// Loadable down-counter that flags when the inter-byte gap inside a packet runs out.
// expired is high once TIMEOUT_CYC-1 enabled cycles have elapsed since the last load.
module ps2_byte_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count;

    // Holds at zero once expired so the flag stays up until the next load.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ps2_pkt_assembler.sv
// Assembles PS/2 mouse bytes into 3-byte packets with resync on error, bad sync bit or timeout.
// Define PS2_PKT_STATS_EN to add the saturating pkt_cnt/drop_cnt statistics ports.
module ps2_pkt_assembler
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    input  logic        byte_err,
`ifdef PS2_PKT_STATS_EN
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt,
`endif
    output logic        ps2pkt_vlk,
    output logic [23:0] ps2pkt_data
);

    ps2_pkt_state_t state;
    logic [7:0]     byte0;
    logic [7:0]     byte1;
    logic           accept;
    logic           pkt_done;
    logic           expired;

    assign accept   = byte_vld & ~byte_err;
    assign pkt_done = (state == PKT_B2) & accept;

    ps2_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_sys (clk_sys),
        .rst     (rst),
        .load    (accept),
        .en      (state != PKT_B0),
        .expired (expired)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state       <= PKT_B0;
            byte0       <= '0;
            byte1       <= '0;
            ps2pkt_vlk  <= 1'b0;
            ps2pkt_data <= '0;
        end else begin
            ps2pkt_vlk <= 1'b0;
            case (state)
                PKT_B0: begin
                    if (accept && is_status_byte(byte_data)) begin
                        byte0 <= byte_data;
                        state <= PKT_B1;
                    end
                end
                PKT_B1: begin
                    if (byte_vld) begin
                        if (byte_err) begin
                            state <= PKT_B0;
                        end else begin
                            byte1 <= byte_data;
                            state <= PKT_B2;
                        end
                    end else if (expired) begin
                        state <= PKT_B0;
                    end
                end
                PKT_B2: begin
                    if (byte_vld) begin
                        state <= PKT_B0;
                        if (!byte_err) begin
                            ps2pkt_vlk  <= 1'b1;
                            ps2pkt_data <= {byte_data, byte1, byte0};
                        end
                    end else if (expired) begin
                        state <= PKT_B0;
                    end
                end
                default: state <= PKT_B0;
            endcase
        end
    end

`ifdef PS2_PKT_STATS_EN
    logic drop_event;

    assign drop_event = (state == PKT_B0) ? (byte_vld & (byte_err | ~is_status_byte(byte_data)))
                                          : (byte_vld ? byte_err : expired);

    // Counters saturate rather than wrap so long runs never read as few events.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_done && pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (drop_event && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_pkt_assembler.sv
// Directed self-checking bench for ps2_pkt_assembler; stats checks compile in with PS2_PKT_STATS_EN.
module tb_ps2_pkt_assembler;

    localparam int TIMEOUT_CYC = 16;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        byte_vld = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_err = 1'b0;
    logic        ps2pkt_vlk;
    logic [23:0] ps2pkt_data;
`ifdef PS2_PKT_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    int checkCount = 0;
    int passCount = 0;
    int pulseCount = 0;
    int backToBack = 0;
    int silentChanges = 0;
    int pulseMark = 0;
    logic        prevVlk = 1'b0;
    logic [23:0] prevData = 24'h0;

    ps2_pkt_assembler #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .byte_vld    (byte_vld),
        .byte_data   (byte_data),
        .byte_err    (byte_err),
`ifdef PS2_PKT_STATS_EN
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt),
`endif
        .ps2pkt_vlk  (ps2pkt_vlk),
        .ps2pkt_data (ps2pkt_data)
    );

    always #5 clk_sys = ~clk_sys;

    // Tracks pulses and flags any data change not accompanied by a pulse.
    always @(posedge clk_sys) begin
        #1;
        if (ps2pkt_vlk) begin
            pulseCount++;
            if (prevVlk) backToBack++;
        end else if (!rst && ps2pkt_data !== prevData) begin
            silentChanges++;
        end
        prevVlk  = ps2pkt_vlk;
        prevData = ps2pkt_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic err);
        byte_data = data;
        byte_err  = err;
        byte_vld  = 1'b1;
        @(negedge clk_sys);
        byte_vld  = 1'b0;
        byte_err  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic checkDrops(input string tag, input int expected);
`ifdef PS2_PKT_STATS_EN
        checkOutput(tag, 32'(drop_cnt), 32'(expected));
`endif
    endtask

    task automatic checkPkts(input string tag, input int expected);
`ifdef PS2_PKT_STATS_EN
        checkOutput(tag, 32'(pkt_cnt), 32'(expected));
`endif
    endtask

    initial begin
        idleCycles(3);
        checkOutput("reset vlk", 32'(ps2pkt_vlk), 32'h0);
        checkOutput("reset data", 32'(ps2pkt_data), 32'h0);
        checkDrops("reset drop_cnt", 0);
        checkPkts("reset pkt_cnt", 0);
        rst = 1'b0;
        idleCycles(2);

        // 1: spaced bytes form one packet
        pulseMark = pulseCount;
        applyStimulus(8'h08, 1'b0);
        idleCycles(10);
        applyStimulus(8'h12, 1'b0);
        idleCycles(10);
        checkOutput("t1 vlk before byte2", 32'(ps2pkt_vlk), 32'h0);
        applyStimulus(8'h34, 1'b0);
        checkOutput("t1 vlk", 32'(ps2pkt_vlk), 32'h1);
        checkOutput("t1 data", 32'(ps2pkt_data), 32'h341208);
        idleCycles(1);
        checkOutput("t1 vlk one cycle", 32'(ps2pkt_vlk), 32'h0);
        checkOutput("t1 pulses", 32'(pulseCount - pulseMark), 32'd1);
        checkPkts("t1 pkt_cnt", 1);
        checkDrops("t1 drop_cnt", 0);

        // 2: leading byte without sync bit is discarded
        applyStimulus(8'h00, 1'b0);
        checkDrops("t2 drop after 00", 1);
        applyStimulus(8'h09, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h01, 1'b0);
        checkOutput("t2 vlk", 32'(ps2pkt_vlk), 32'h1);
        checkOutput("t2 data", 32'(ps2pkt_data), 32'h01FF09);
        checkPkts("t2 pkt_cnt", 2);
        idleCycles(2);

        // 3: stalled packet is abandoned after the timeout
        pulseMark = pulseCount;
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h12, 1'b0);
        idleCycles(TIMEOUT_CYC);
        checkOutput("t3 no pulse after stall", 32'(pulseCount - pulseMark), 32'd0);
        checkDrops("t3 drop after timeout", 2);
        applyStimulus(8'h08, 1'b0);
        checkOutput("t3 held data", 32'(ps2pkt_data), 32'h01FF09);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        checkOutput("t3 data", 32'(ps2pkt_data), 32'hBBAA08);
        checkOutput("t3 pulses", 32'(pulseCount - pulseMark), 32'd1);
        checkDrops("t3 drop_cnt", 2);
        idleCycles(2);

        // 4: bytes landing on the exact expiry cycle are accepted
        applyStimulus(8'h08, 1'b0);
        idleCycles(TIMEOUT_CYC - 1);
        applyStimulus(8'h56, 1'b0);
        idleCycles(TIMEOUT_CYC - 1);
        applyStimulus(8'h78, 1'b0);
        checkOutput("t4 vlk", 32'(ps2pkt_vlk), 32'h1);
        checkOutput("t4 data", 32'(ps2pkt_data), 32'h785608);
        checkDrops("t4 drop_cnt", 2);
        idleCycles(2);

        // 5: errored byte abandons the packet
        pulseMark = pulseCount;
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h18, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("t5 data", 32'(ps2pkt_data), 32'h020118);
        checkOutput("t5 pulses", 32'(pulseCount - pulseMark), 32'd1);
        checkDrops("t5 drop_cnt", 3);
        idleCycles(2);

        // 6: reset mid-packet
        applyStimulus(8'h08, 1'b0);
        rst = 1'b1;
        idleCycles(1);
        checkOutput("t6 reset vlk", 32'(ps2pkt_vlk), 32'h0);
        checkOutput("t6 reset data", 32'(ps2pkt_data), 32'h0);
        checkDrops("t6 reset drop_cnt", 0);
        checkPkts("t6 reset pkt_cnt", 0);
        idleCycles(1);
        rst = 1'b0;
        pulseMark = pulseCount;
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("t6 data", 32'(ps2pkt_data), 32'h020108);
        checkOutput("t6 pulses", 32'(pulseCount - pulseMark), 32'd1);
        checkDrops("t6 drop_cnt", 0);
        checkPkts("t6 pkt_cnt", 1);

        // 7: back-to-back packets, next status byte during the pulse
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        checkOutput("t7 first data", 32'(ps2pkt_data), 32'h221108);
        applyStimulus(8'h08, 1'b0);
        checkOutput("t7 vlk drop", 32'(ps2pkt_vlk), 32'h0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        checkOutput("t7 second vlk", 32'(ps2pkt_vlk), 32'h1);
        checkOutput("t7 second data", 32'(ps2pkt_data), 32'h443308);
        idleCycles(2);

        // 8: error on Y byte, then errored status byte, then a clean packet
        pulseMark = pulseCount;
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b1);
        checkOutput("t8 no pulse on bad Y", 32'(ps2pkt_vlk), 32'h0);
        applyStimulus(8'h09, 1'b1);
        applyStimulus(8'h0C, 1'b0);
        applyStimulus(8'h0D, 1'b0);
        applyStimulus(8'h0E, 1'b0);
        checkOutput("t8 data", 32'(ps2pkt_data), 32'h0E0D0C);
        checkOutput("t8 pulses", 32'(pulseCount - pulseMark), 32'd1);
        checkDrops("t8 drop_cnt", 2);
        checkPkts("t8 pkt_cnt", 4);
        idleCycles(3);

        checkOutput("no consecutive pulses", 32'(backToBack), 32'd0);
        checkOutput("no silent data change", 32'(silentChanges), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
